// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, state encoding and address type for the icache line-fill path
package icache_pkg;

    localparam int unsigned ClWidth       = 512;
    localparam int unsigned BeatWidth     = 64;
    localparam int unsigned Beats         = ClWidth / BeatWidth;
    localparam int unsigned BeatIdxWidth  = $clog2(Beats);
    localparam int unsigned ClOffsetWidth = 6;

    typedef logic [63:0] cl_addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_DONE
    } icfill_state_t;

    // Drops the byte offset so the downstream bus always sees a line-aligned address
    function automatic cl_addr_t line_align(input cl_addr_t a);
        return a & ~((cl_addr_t'(1) << ClOffsetWidth) - cl_addr_t'(1));
    endfunction

endpackage

// File: rtl/line_assembler.sv
// line_assembler: beat counter plus indexed write of memory beats into a cache-line register
module line_assembler
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 beat_valid,
    input  logic [BeatWidth-1:0] beat_data,
    output logic                 last,
    output logic [ClWidth-1:0]   line
);

    logic [BeatIdxWidth-1:0] idx_q, idx_d;
    logic [ClWidth-1:0]      line_q, line_d;

    // Next beat slot and line contents; the counter wraps 7->0 on the final beat
    always_comb begin
        idx_d  = clear ? '0 : (beat_valid ? idx_q + 1'b1 : idx_q);
        line_d = line_q;
        if (beat_valid)
            line_d[BeatWidth*idx_q +: BeatWidth] = beat_data;
    end

    // Counter and line storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            line_q <= '0;
        end else begin
            idx_q  <= idx_d;
            line_q <= line_d;
        end
    end

    assign last = beat_valid && (idx_q == BeatIdxWidth'(Beats - 1));
    assign line = line_q;

endmodule

// File: rtl/icache_fill_responder.sv
// icache_fill_responder: accepts one icache line request, issues one burst read, returns the 512-bit line
// Optional watchdog: define ICFILL_TIMEOUT_EN to abort a stuck fill with ierror after TimeoutCycles idle cycles
module icache_fill_responder
    import icache_pkg::*;
`ifdef ICFILL_TIMEOUT_EN
#(
    parameter int unsigned TimeoutCycles = 1024
)
`endif
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 irequest,
    output logic                 ireqack,
    input  cl_addr_t             iaddr,
    output logic [ClWidth-1:0]   idata,
    output logic                 idone,
    output logic                 ierror,
    output logic                 mem_reqcyc,
    input  logic                 mem_reqack,
    output cl_addr_t             mem_req,
    input  logic                 mem_respcyc,
    input  logic [BeatWidth-1:0] mem_resp,
    output logic                 mem_respack
);

    icfill_state_t      state_q, state_d;
    logic               ireqack_q;
    cl_addr_t           mem_req_q, mem_req_d;
    logic [ClWidth-1:0] hold_q, hold_d;
    logic [ClWidth-1:0] line;
    logic               accept, beat, last, tmo, fail;

    assign accept = (state_q == S_IDLE) && irequest;
    assign beat   = (state_q == S_DATA) && mem_respcyc;

    line_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .beat_valid (beat),
        .beat_data  (mem_resp),
        .last       (last),
        .line       (line)
    );

`ifdef ICFILL_TIMEOUT_EN
    localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);

    logic [TmoWidth-1:0] tmo_q, tmo_d;
    logic                busy, err_q;

    assign busy = (state_q == S_REQ) || (state_q == S_DATA);
    assign tmo  = busy && !beat && !((state_q == S_REQ) && mem_reqack)
                  && (tmo_q == TmoWidth'(TimeoutCycles - 1));
    assign fail = err_q;

    // Idle-cycle counter: restarts on request accept and on every accepted beat
    always_comb tmo_d = (accept || beat) ? '0 : (busy ? tmo_q + 1'b1 : tmo_q);

    // Watchdog state; err_q is only ever high in the S_DONE cycle that follows a timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= tmo;
        end
    end
`else
    assign tmo  = 1'b0;
    assign fail = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: request ack wins over a simultaneous timeout
    always_comb begin
        state_d = (state_q == S_IDLE) ? (irequest ? S_REQ : S_IDLE)
                : (state_q == S_REQ)  ? (mem_reqack ? S_DATA : (tmo ? S_DONE : S_REQ))
                : (state_q == S_DATA) ? ((last || tmo) ? S_DONE : S_DATA)
                : S_IDLE;
    end

    // Outputs: idata shows the fresh line in the done cycle, then the held copy until the next done
    always_comb begin
        mem_reqcyc  = (state_q == S_REQ);
        idone       = (state_q == S_DONE);
        ierror      = idone && fail;
        idata       = idone ? (fail ? '0 : line) : hold_q;
        mem_respack = mem_respcyc;
        ireqack     = ireqack_q;
        mem_req     = mem_req_q;
        mem_req_d   = accept ? line_align(iaddr) : mem_req_q;
        hold_d      = idone ? idata : hold_q;
    end

    // Request capture and returned-line hold register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ireqack_q <= 1'b0;
            mem_req_q <= '0;
            hold_q    <= '0;
        end else begin
            ireqack_q <= accept;
            mem_req_q <= mem_req_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_icache_fill_responder.sv
// tb_icache_fill_responder: directed fills with a scoreboard that checks every idone against queued expectations
module tb_icache_fill_responder;
    import icache_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           irequest = 1'b0;
    logic           mem_reqack = 1'b0;
    logic           mem_respcyc = 1'b0;
    logic [63:0]    iaddr = '0;
    logic [63:0]    mem_resp = '0;
    logic           ireqack, idone, ierror, mem_reqcyc, mem_respack;
    logic [511:0]   idata;
    logic [63:0]    mem_req;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acks = 0;
    logic [511:0] last_line = '0;

    typedef struct {
        logic [511:0] line;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t q[$];

`ifdef ICFILL_TIMEOUT_EN
    icache_fill_responder #(.TimeoutCycles(16)) dut (
`else
    icache_fill_responder dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .irequest    (irequest),
        .ireqack     (ireqack),
        .iaddr       (iaddr),
        .idata       (idata),
        .idone       (idone),
        .ierror      (ierror),
        .mem_reqcyc  (mem_reqcyc),
        .mem_reqack  (mem_reqack),
        .mem_req     (mem_req),
        .mem_respcyc (mem_respcyc),
        .mem_resp    (mem_resp),
        .mem_respack (mem_respack)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every idone; otherwise idata must hold the last returned line
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_line = '0;
            end else begin
                if (ireqack) acks++;
                if (idone) begin
                    if (q.size() == 0) begin
                        chk("unexpected_idone", idone, 0);
                    end else begin
                        e = q.pop_front();
                        chk("idata", idata, e.line);
                        chk("ierror", ierror, e.err);
                        chk("idone_cycle", cyc, e.cyc);
                        last_line = e.line;
                    end
                end else begin
                    chk("idata_hold", idata, last_line);
                    chk("ierror_idle", ierror, 0);
                end
            end
        end
    end

    task automatic fill(input logic [63:0] addr, input int d, input int g, input logic [63:0] pat, input bit hold);
        logic [511:0] l;
        int           a0;
        exp_t         e;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = pat | 64'(k);
        a0     = acks;
        e.line = l;
        e.err  = 1'b0;
        e.cyc  = cyc + 10 + d + 7 * g;
        q.push_back(e);
        irequest = 1'b1;
        iaddr    = addr;
        step;
        irequest = hold;
        iaddr    = ~addr;
        chk("ireqack_rise", ireqack, 1);
        chk("mem_reqcyc_rise", mem_reqcyc, 1);
        chk("mem_req", mem_req, addr & ~64'h3F);
        for (int i = 0; i < d; i++) begin
            step;
            chk("mem_reqcyc_hold", mem_reqcyc, 1);
            chk("mem_req_hold", mem_req, addr & ~64'h3F);
        end
        mem_reqack = 1'b1;
        step;
        mem_reqack = 1'b0;
        chk("mem_reqcyc_drop", mem_reqcyc, 0);
        for (int k = 0; k < 8; k++) begin
            mem_respcyc = 1'b1;
            mem_resp    = l[64*k +: 64];
            #1;
            chk("mem_respack", mem_respack, 1);
            step;
            mem_respcyc = 1'b0;
            if (k < 7) repeat (g) step;
        end
        chk("ireqack_once", acks - a0, 1);
        chk("ireqack_low_done", ireqack, 0);
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && q.size() != 0; i++) step;
        chk("idone_seen", q.size(), 0);
        q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ireqack"}, ireqack, 0);
        chk({tag, "_idone"}, idone, 0);
        chk({tag, "_ierror"}, ierror, 0);
        chk({tag, "_mem_reqcyc"}, mem_reqcyc, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_idata"}, idata, 0);
    endtask

    initial begin
        #2 reset = 1'b1;
        step;
        step;
        check_reset_values("reset");
        chk("reset_mem_respack", mem_respack, 0);
        reset = 1'b0;
        step;

        // Zero-wait fill, beats 0..7
        fill(64'h1040, 0, 0, 64'h0, 1'b0);
        drain;

        // Misaligned address, reqack after 3 cycles, one stall between beats
        fill(64'h107F, 3, 1, 64'hBEEF_0000_0000_0000, 1'b0);
        drain;

        // Held request: ignored until S_IDLE, old line held through the next fill
        fill(64'h2000, 1, 0, 64'h1111_0000_0000_0000, 1'b1);
        step;
        chk("held_no_early_ack", ireqack, 0);
        fill(64'h3000, 0, 0, 64'h2222_0000_0000_0000, 1'b0);
        drain;

        // Reset after beat 4; beats 5..7 then arrive as strays
        irequest = 1'b1;
        iaddr    = 64'h4000;
        step;
        irequest   = 1'b0;
        mem_reqack = 1'b1;
        step;
        mem_reqack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_respcyc = 1'b1;
            mem_resp    = 64'(k);
            step;
        end
        mem_respcyc = 1'b0;
        reset       = 1'b1;
        #1;
        check_reset_values("midfill");
        step;
        reset = 1'b0;
        for (int k = 5; k < 8; k++) begin
            mem_respcyc = 1'b1;
            mem_resp    = 64'hDEAD_0000 + 64'(k);
            #1;
            chk("stray_respack", mem_respack, 1);
            step;
        end
        mem_respcyc = 1'b0;
        step;
        chk("stray_no_reqcyc", mem_reqcyc, 0);
        fill(64'h4000, 0, 2, 64'h4444_0000_0000_0000, 1'b0);
        drain;

        // Beat-order pattern
        fill(64'h5040, 1, 0, 64'hA5A5_0000_0000_0000, 1'b0);
        drain;

`ifdef ICFILL_TIMEOUT_EN
        // Memory never acknowledges: watchdog fires 16 cycles after entering S_REQ
        begin
            exp_t e;
            e.line   = '0;
            e.err    = 1'b1;
            e.cyc    = cyc + 17;
            q.push_back(e);
            irequest = 1'b1;
            iaddr    = 64'h6000;
            step;
            irequest = 1'b0;
            chk("tmo_reqcyc", mem_reqcyc, 1);
            drain;
            chk("tmo_reqcyc_drop", mem_reqcyc, 0);
            step;
            fill(64'h6040, 0, 0, 64'h6666_0000_0000_0000, 1'b0);
            drain;
        end
`endif

        step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
